// File: rtl/vga_rx.sv
// Sync-edge driven VGA receiver: rebuilds pixel coordinates from hsync_n/vsync_n, emits tagged pixels and timing stats.
// Optional frame CRC over visible pixels is compiled in when VGA_RX_CRC_EN is defined.
module vga_rx #(
  parameter int H_VISIBLE = 640,
  parameter int H_BACK    = 48,
  parameter int H_TOTAL   = 800,
  parameter int V_VISIBLE = 480,
  parameter int V_BACK    = 33,
  parameter int V_TOTAL   = 525
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hsync_n,
  input  logic       vsync_n,
  input  logic [5:0] rgb,
  output logic       px_valid,
  output logic [9:0] px_x,
  output logic [9:0] px_y,
  output logic [5:0] px_rgb,
  output logic       px_sof,
  output logic       frame_done,
  output logic [9:0] line_len,
  output logic [9:0] frame_lines,
  output logic       locked,
  output logic [15:0] frame_crc
);

  localparam logic [9:0] H_LO  = 10'(H_BACK);
  localparam logic [9:0] H_HI  = 10'(H_BACK + H_VISIBLE);
  localparam logic [9:0] V_LO  = 10'(V_BACK);
  localparam logic [9:0] V_HI  = 10'(V_BACK + V_VISIBLE);
  localparam logic [9:0] H_TOT = 10'(H_TOTAL);
  localparam logic [9:0] V_TOT = 10'(V_TOTAL);
  localparam logic [9:0] SAT   = 10'h3FF;

  typedef enum logic [1:0] {SEEK, FRAME, DONE, WAIT} state_t;
  state_t state;

  logic       hs1, hs2, vs1, vs2;
  logic [5:0] rgb1;
  logic [9:0] hcnt, vcnt;
  logic [9:0] hcnt_cur, vcnt_cur, x_cur, y_cur;
  logic       hrise, vrise, vfall, emit;

  assign hrise = hs1 & ~hs2;
  assign vrise = vs1 & ~vs2;
  assign vfall = ~vs1 & vs2;

  // hcnt/vcnt hold the position of the previous stage-1 sample; *_cur is the one now in stage 1
  always_comb begin
    hcnt_cur = hrise ? 10'd0 : ((hcnt == SAT) ? hcnt : hcnt + 10'd1);
    vcnt_cur = vcnt;
    if (vrise)
      vcnt_cur = 10'd0;
    else if (hrise && vcnt != SAT)
      vcnt_cur = vcnt + 10'd1;
    x_cur = hcnt_cur - H_LO;
    y_cur = vcnt_cur - V_LO;
    emit  = (state == FRAME) && (hcnt_cur >= H_LO) && (hcnt_cur < H_HI) &&
            (vcnt_cur >= V_LO) && (vcnt_cur < V_HI);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hs1 <= 1'b1; hs2 <= 1'b1; vs1 <= 1'b1; vs2 <= 1'b1;
      rgb1 <= '0; hcnt <= '0; vcnt <= '0;
      px_valid <= 1'b0; px_x <= '0; px_y <= '0; px_rgb <= '0; px_sof <= 1'b0;
      frame_done <= 1'b0; line_len <= '0; frame_lines <= '0; locked <= 1'b0;
      state <= SEEK;
    end else begin
      hs1 <= hsync_n; hs2 <= hs1;
      vs1 <= vsync_n; vs2 <= vs1;
      rgb1 <= rgb;
      hcnt <= hcnt_cur;
      vcnt <= vcnt_cur;
      if (hrise)
        line_len <= (hcnt == SAT) ? SAT : hcnt + 10'd1;
      px_valid <= emit;
      px_sof   <= emit && (x_cur == 10'd0) && (y_cur == 10'd0);
      if (emit) begin
        px_x   <= x_cur;
        px_y   <= y_cur;
        px_rgb <= rgb1;
      end
      frame_done <= 1'b0;
      case (state)
        SEEK: if (vrise) state <= FRAME;
        FRAME: begin
          // a counter pinned at full scale means a sync has gone missing
          if (hcnt_cur == SAT || vcnt_cur == SAT) begin
            state  <= SEEK;
            locked <= 1'b0;
          end else if (vfall) begin
            state <= DONE;
          end
        end
        DONE: begin
          frame_done  <= 1'b1;
          frame_lines <= vcnt;
          locked      <= (vcnt == V_TOT) && (line_len == H_TOT);
          state       <= WAIT;
        end
        default: if (vrise) state <= FRAME;
      endcase
    end
  end

`ifdef VGA_RX_CRC_EN
  logic [15:0] crc;

  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 7; i >= 0; i--)
      r = (r[15] ^ d[i]) ? ((r << 1) ^ 16'h1021) : (r << 1);
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      crc       <= 16'hFFFF;
      frame_crc <= '0;
    end else begin
      if (vrise)
        crc <= 16'hFFFF;
      else if (emit)
        crc <= crc_byte(crc, {2'b00, rgb1});
      if (state == DONE)
        frame_crc <= crc;
    end
  end
`else
  assign frame_crc = 16'h0000;
`endif

endmodule

// File: tb/tb_vga_rx.sv
// Directed frame sequences with random colour data, checked against a geometry-derived pixel model.
// Uses a shrunken raster so whole frames fit in a short run.
module tb_vga_rx;
  localparam int HV = 16, HB = 6, HT = 40, VV = 12, VB = 4, VT = 24, HS = 4;

  logic        clk = 1'b0;
  logic        reset, hsync_n, vsync_n;
  logic [5:0]  rgb;
  logic        px_valid, px_sof, frame_done, locked;
  logic [9:0]  px_x, px_y, line_len, frame_lines;
  logic [5:0]  px_rgb;
  logic [15:0] frame_crc;

  always #5 clk = ~clk;

  vga_rx #(.H_VISIBLE(HV), .H_BACK(HB), .H_TOTAL(HT),
           .V_VISIBLE(VV), .V_BACK(VB), .V_TOTAL(VT)) dut (
    .clk(clk), .reset(reset), .hsync_n(hsync_n), .vsync_n(vsync_n), .rgb(rgb),
    .px_valid(px_valid), .px_x(px_x), .px_y(px_y), .px_rgb(px_rgb), .px_sof(px_sof),
    .frame_done(frame_done), .line_len(line_len), .frame_lines(frame_lines),
    .locked(locked), .frame_crc(frame_crc));

  int checks = 0, fails = 0;
  int n_valid, pix_err, done_cnt, fx, fy, fsof, lx, ly;
  bit seen;
  bit ev_prev = 1'b0;
  int ex_prev = 0, ey_prev = 0;
  logic [5:0]  ergb_prev = '0;
  logic [9:0]  d_len, d_lines;
  logic        d_lock;
  logic [15:0] d_crc, crc_model;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // CRC-16/CCITT-FALSE as polynomial division of the message, one bit at a time
  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {d, 8'h00};
    for (int i = 0; i < 8; i++)
      r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    return r;
  endfunction

  task automatic step(input logic h, input logic v, input logic [5:0] c,
                      input bit ev, input int ex, input int ey, input bit rst);
    hsync_n = h; vsync_n = v; rgb = c; reset = rst;
    if (ev) crc_model = crc_upd(crc_model, {2'b00, c});
    @(posedge clk); #1;
    if (!rst) begin
      if (px_valid !== ev_prev)
        pix_err++;
      else if (ev_prev && (px_x !== 10'(ex_prev) || px_y !== 10'(ey_prev) ||
               px_rgb !== ergb_prev || px_sof !== (ex_prev == 0 && ey_prev == 0)))
        pix_err++;
    end
    if (px_valid === 1'b1) begin
      n_valid++;
      if (!seen) begin fx = px_x; fy = px_y; fsof = px_sof; end
      seen = 1'b1;
      lx = px_x; ly = px_y;
    end
    if (frame_done === 1'b1) begin
      done_cnt++;
      d_len = line_len; d_lines = frame_lines; d_lock = locked; d_crc = frame_crc;
    end
    ev_prev = rst ? 1'b0 : ev;
    ex_prev = ex; ey_prev = ey; ergb_prev = c;
  endtask

  // yoff: frame line index minus y; tail 1 = short vsync pulse ending before the next hsync rise,
  // tail 2 = vsync rises together with the next hsync rise.
  task automatic frame(input int yoff, input int tail, input int long_line, input int stuck_line,
                       input int cut_line, input int rst_line, input int rmode, input bit emit);
    n_valid = 0; pix_err = 0; done_cnt = 0; seen = 1'b0; crc_model = 16'hFFFF;
    for (int l = 0; l < VT; l++) begin
      int len, y;
      len = (l == long_line) ? HT + 1 : (l == stuck_line) ? 1100 + HS : HT;
      y = l - yoff;
      for (int p = 0; p < len; p++) begin
        int x;
        logic h, v;
        logic [5:0] c;
        bit vis, rs;
        x = p - HB;
        h = (p < len - HS);
        v = !(l == VT - 1 && p >= len - 20 && (tail == 2 || p < len - 10));
        vis = emit && l < cut_line && x >= 0 && x < HV && y >= 0 && y < VV;
        c = (rmode == 0) ? 6'($urandom) : (rmode == 1) ? x[5:0] : 6'h00;
        rs = (l == rst_line && p == 0);
        step(h, v, c, vis, x, y, rs);
        if (rs) begin
          chk("rst_px_valid", px_valid, 0);   chk("rst_px_x", px_x, 0);
          chk("rst_px_y", px_y, 0);           chk("rst_px_rgb", px_rgb, 0);
          chk("rst_px_sof", px_sof, 0);       chk("rst_frame_done", frame_done, 0);
          chk("rst_line_len", line_len, 0);   chk("rst_frame_lines", frame_lines, 0);
          chk("rst_locked", locked, 0);       chk("rst_frame_crc", frame_crc, 0);
        end
        if (l == stuck_line && p == len - 1)
          chk("stuck_locked", locked, 0);
      end
    end
  endtask

  task automatic check_frame(input string nm, input int exp_pix, input int exp_lx, input int exp_ly,
                             input int exp_done, input int exp_len, input int exp_lines, input int exp_lock);
    logic [15:0] ecrc;
`ifdef VGA_RX_CRC_EN
    ecrc = crc_model;
`else
    ecrc = 16'h0000;
`endif
    chk({nm, "_pixcount"}, n_valid, exp_pix);
    chk({nm, "_pixerr"}, pix_err, 0);
    chk({nm, "_donecount"}, done_cnt, exp_done);
    if (exp_pix > 0) begin
      chk({nm, "_first_x"}, fx, 0);  chk({nm, "_first_y"}, fy, 0);
      chk({nm, "_first_sof"}, fsof, 1);
      chk({nm, "_last_x"}, lx, exp_lx); chk({nm, "_last_y"}, ly, exp_ly);
    end
    if (exp_done > 0) begin
      chk({nm, "_line_len"}, d_len, exp_len);
      chk({nm, "_frame_lines"}, d_lines, exp_lines);
      chk({nm, "_locked"}, d_lock, exp_lock);
      chk({nm, "_crc"}, d_crc, ecrc);
    end
    $display("frame %s: %0d pixels, %0d pixel errors, %0d done pulses, line_len=%0d frame_lines=%0d locked=%0d crc=%h",
             nm, n_valid, pix_err, done_cnt, d_len, d_lines, d_lock, d_crc);
  endtask

  initial begin
    reset = 1'b1; hsync_n = 1'b1; vsync_n = 1'b1; rgb = '0;
    d_len = '0; d_lines = '0; d_lock = 1'b0; d_crc = '0; crc_model = 16'hFFFF;
    repeat (3) @(posedge clk);
    #1;
    chk("init_px_valid", px_valid, 0);     chk("init_frame_done", frame_done, 0);
    chk("init_line_len", line_len, 0);     chk("init_frame_lines", frame_lines, 0);
    chk("init_locked", locked, 0);         chk("init_frame_crc", frame_crc, 0);
    chk("init_px_xy", {px_x, px_y}, 0);

    // partial frame with no preceding vrise: nothing emitted, no frame_done
    frame(3, 1, -1, -1, 0, -1, 0, 1'b0);
    check_frame("f0_unlocked", 0, 0, 0, 0, 0, 0, 0);
    frame(3, 1, -1, -1, VT, -1, 0, 1'b1);
    check_frame("f1_random", HV * VV, HV - 1, VV - 1, 1, HT, VT, 1);
    frame(3, 1, -1, -1, VT, -1, 1, 1'b1);
    check_frame("f2_xramp", HV * VV, HV - 1, VV - 1, 1, HT, VT, 1);
    frame(3, 1, VT - 2, -1, VT, -1, 0, 1'b1);
    check_frame("f3_longline", HV * VV, HV - 1, VV - 1, 1, HT + 1, VT, 0);
    frame(3, 1, -1, -1, VT, -1, 0, 1'b1);
    check_frame("f4_relock", HV * VV, HV - 1, VV - 1, 1, HT, VT, 1);
    frame(3, 1, -1, 6, 7, -1, 0, 1'b1);
    check_frame("f5_stuck", (6 - 3 + 1) * HV, HV - 1, 6 - 3, 0, 0, 0, 0);
    frame(3, 2, -1, -1, VT, -1, 0, 1'b1);
    check_frame("f6_tail2", HV * VV, HV - 1, VV - 1, 1, HT, VT, 1);
    // vrise coincided with hrise: that edge is not counted, so y=0 lands one line later
    frame(4, 1, -1, -1, VT, -1, 0, 1'b1);
    check_frame("f7_coincide", HV * VV, HV - 1, VV - 1, 1, HT, VT - 1, 0);
    frame(3, 1, -1, -1, 10, 10, 0, 1'b1);
    check_frame("f8_reset", (10 - 3) * HV, HV - 1, 10 - 3 - 1, 0, 0, 0, 0);
    frame(3, 1, -1, -1, VT, -1, 2, 1'b1);
    check_frame("f9_zero", HV * VV, HV - 1, VV - 1, 1, HT, VT, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
